// File: rtl/key_ctrl_multi.sv
// Multi-channel play/stop/clear key controller with EEPROM load/save handshakes.
// Optional: define SAVE_ON_STOP_EN to also save a channel when key_start stops it.
module key_ctrl_multi #(
  parameter int N_CH        = 2,
  parameter int CH_W        = 1,
  parameter int ACK_TIMEOUT = 1000
) (
  input  logic            sclk,
  input  logic            rst,
  input  logic            key_start,
  input  logic            key_clr,
  input  logic            key_sel,
  input  logic            load_ack,
  input  logic            save_ack,
  output logic [N_CH-1:0] play_state,
  output logic [CH_W-1:0] sel_ch,
  output logic [N_CH-1:0] clr_pulse,
  output logic            load_req,
  output logic            save_req,
  output logic [CH_W-1:0] save_ch,
  output logic            busy,
  output logic            err
);

  localparam int CNT_W = $clog2(ACK_TIMEOUT + 1);

  typedef enum logic [1:0] {S_LOAD, S_IDLE, S_SAVE} state_t;

  state_t          state_q, state_d;
  logic [N_CH-1:0] play_q, play_d;
  logic [N_CH-1:0] clr_q, clr_d;
  logic [CH_W-1:0] sel_q, sel_d;
  logic [CH_W-1:0] sch_q, sch_d;
  logic            lreq_q, lreq_d;
  logic            sreq_q, sreq_d;
  logic            err_q, err_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic            timeout;
  logic            sel_playing;

  // cnt_q counts cycles the request line has been high, starting at 0.
  assign timeout     = (cnt_q == CNT_W'(ACK_TIMEOUT - 1));
  assign sel_playing = play_q[sel_q];

  always_ff @(posedge sclk or posedge rst) begin
    if (rst) begin
      state_q <= S_LOAD;
      play_q  <= '0;
      clr_q   <= '0;
      sel_q   <= '0;
      sch_q   <= '0;
      lreq_q  <= 1'b0;
      sreq_q  <= 1'b0;
      err_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      play_q  <= play_d;
      clr_q   <= clr_d;
      sel_q   <= sel_d;
      sch_q   <= sch_d;
      lreq_q  <= lreq_d;
      sreq_q  <= sreq_d;
      err_q   <= err_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    play_d  = play_q;
    clr_d   = '0;
    sel_d   = sel_q;
    sch_d   = sch_q;
    lreq_d  = lreq_q;
    sreq_d  = sreq_q;
    err_d   = err_q;
    cnt_d   = cnt_q + CNT_W'(1);
    case (state_q)
      S_LOAD: begin
        // The first cycle after reset release raises the request; acks before that are ignored.
        if (!lreq_q) begin
          lreq_d = 1'b1;
          cnt_d  = '0;
        end else if (load_ack) begin
          lreq_d  = 1'b0;
          state_d = S_IDLE;
          cnt_d   = '0;
        end else if (timeout) begin
          err_d   = 1'b1;
          lreq_d  = 1'b0;
          state_d = S_IDLE;
          cnt_d   = '0;
        end
      end
      S_IDLE: begin
        cnt_d = '0;
        if (key_start) begin
          play_d[sel_q] = ~sel_playing;
`ifdef SAVE_ON_STOP_EN
          if (sel_playing) begin
            sch_d   = sel_q;
            sreq_d  = 1'b1;
            state_d = S_SAVE;
          end
`endif
        end else if (key_clr) begin
          if (!sel_playing) begin
            clr_d[sel_q] = 1'b1;
            sch_d        = sel_q;
            sreq_d       = 1'b1;
            state_d      = S_SAVE;
          end
        end else if (key_sel) begin
          if (sel_q == CH_W'(N_CH - 1)) sel_d = '0;
          else                          sel_d = sel_q + CH_W'(1);
        end
      end
      S_SAVE: begin
        // Ack wins over a timeout expiring in the same cycle.
        if (save_ack) begin
          sreq_d  = 1'b0;
          state_d = S_IDLE;
          cnt_d   = '0;
        end else if (timeout) begin
          err_d   = 1'b1;
          sreq_d  = 1'b0;
          state_d = S_IDLE;
          cnt_d   = '0;
        end
      end
      default: begin
        state_d = S_LOAD;
        lreq_d  = 1'b0;
        sreq_d  = 1'b0;
        cnt_d   = '0;
      end
    endcase
  end

  assign play_state = play_q;
  assign sel_ch     = sel_q;
  assign clr_pulse  = clr_q;
  assign load_req   = lreq_q;
  assign save_req   = sreq_q;
  assign save_ch    = sch_q;
  assign busy       = lreq_q | sreq_q;
  assign err        = err_q;

endmodule

// File: tb/tb_key_ctrl_multi.sv
// Randomized and directed bench for key_ctrl_multi against a behavioural model (N_CH=3, ACK_TIMEOUT=8).
module tb_key_ctrl_multi;

  localparam int N_CH = 3;
  localparam int CH_W = 2;
  localparam int TO   = 8;

  logic            sclk = 1'b0;
  logic            rst = 1'b1;
  logic            key_start = 1'b0, key_clr = 1'b0, key_sel = 1'b0;
  logic            load_ack = 1'b0, save_ack = 1'b0;
  logic [N_CH-1:0] play_state, clr_pulse;
  logic [CH_W-1:0] sel_ch, save_ch;
  logic            load_req, save_req, busy, err;

  key_ctrl_multi #(.N_CH(N_CH), .CH_W(CH_W), .ACK_TIMEOUT(TO)) dut (
    .sclk(sclk), .rst(rst), .key_start(key_start), .key_clr(key_clr), .key_sel(key_sel),
    .load_ack(load_ack), .save_ack(save_ack), .play_state(play_state), .sel_ch(sel_ch),
    .clr_pulse(clr_pulse), .load_req(load_req), .save_req(save_req), .save_ch(save_ch),
    .busy(busy), .err(err)
  );

  always #5 sclk = ~sclk;

  int n_cmp = 0;
  int n_err = 0;

  // Reference model: request lines plus the age of the outstanding request.
  logic [N_CH-1:0] m_play, m_clr;
  int              m_sel, m_sch, m_age;
  bit              m_lreq, m_sreq, m_err, m_loaded;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_play = '0; m_clr = '0; m_sel = 0; m_sch = 0; m_age = 0;
    m_lreq = 0; m_sreq = 0; m_err = 0; m_loaded = 0;
  endtask

  task automatic start_save();
    m_sreq = 1; m_sch = m_sel; m_age = 1;
  endtask

  task automatic model_step(input bit ks, input bit kc, input bit ksl, input bit la, input bit sa);
    m_clr = '0;
    if (m_lreq || m_sreq) begin
      if ((m_lreq && la) || (m_sreq && sa)) begin
        m_lreq = 0; m_sreq = 0;
      end else if (m_age == TO) begin
        m_err = 1; m_lreq = 0; m_sreq = 0;
      end else begin
        m_age++;
      end
    end else if (!m_loaded) begin
      m_loaded = 1; m_lreq = 1; m_age = 1;
    end else if (ks) begin
`ifdef SAVE_ON_STOP_EN
      if (m_play[m_sel]) start_save();
`endif
      m_play[m_sel] = ~m_play[m_sel];
    end else if (kc) begin
      if (!m_play[m_sel]) begin
        m_clr[m_sel] = 1'b1;
        start_save();
      end
    end else if (ksl) begin
      m_sel = (m_sel + 1) % N_CH;
    end
  endtask

  task automatic compare_all();
    check_eq("play_state", 32'(play_state), 32'(m_play));
    check_eq("sel_ch", 32'(sel_ch), m_sel);
    check_eq("clr_pulse", 32'(clr_pulse), 32'(m_clr));
    check_eq("load_req", 32'(load_req), 32'(m_lreq));
    check_eq("save_req", 32'(save_req), 32'(m_sreq));
    check_eq("save_ch", 32'(save_ch), m_sch);
    check_eq("busy", 32'(busy), 32'(m_lreq | m_sreq));
    check_eq("err", 32'(err), 32'(m_err));
  endtask

  task automatic cyc(input bit ks, input bit kc, input bit ksl, input bit la, input bit sa);
    key_start = ks; key_clr = kc; key_sel = ksl; load_ack = la; save_ack = sa;
    @(posedge sclk);
    model_step(ks, kc, ksl, la, sa);
    @(negedge sclk);
    compare_all();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(0, 0, 0, 0, 0);
  endtask

  // Asserts rst between edges; request lines must drop without waiting for a clock.
  task automatic mid_reset();
    key_start = 0; key_clr = 0; key_sel = 0; load_ack = 0; save_ack = 0;
    #2 rst = 1'b1;
    #1;
    check_eq("rst_load_req", 32'(load_req), 0);
    check_eq("rst_save_req", 32'(save_req), 0);
    check_eq("rst_busy", 32'(busy), 0);
    check_eq("rst_err", 32'(err), 0);
    check_eq("rst_play", 32'(play_state), 0);
    model_reset();
    @(negedge sclk);
    rst = 1'b0;
  endtask

  task automatic load_ok();
    cyc(0, 0, 0, 0, 0);
    check_eq("load_req_up", 32'(load_req), 1);
    check_eq("busy_up", 32'(busy), 1);
    idle(3);
    cyc(0, 0, 0, 1, 0);
    check_eq("load_req_down", 32'(load_req), 0);
    check_eq("load_err", 32'(err), 0);
  endtask

  initial begin
    model_reset();
    repeat (2) @(negedge sclk);
    check_eq("reset_play", 32'(play_state), 0);
    check_eq("reset_sel", 32'(sel_ch), 0);
    check_eq("reset_load_req", 32'(load_req), 0);
    check_eq("reset_busy", 32'(busy), 0);
    check_eq("reset_err", 32'(err), 0);
    rst = 1'b0;
    load_ok();

    cyc(0, 0, 1, 0, 0); check_eq("sel_1", 32'(sel_ch), 1);
    cyc(0, 0, 1, 0, 0); check_eq("sel_2", 32'(sel_ch), 2);
    cyc(0, 0, 1, 0, 0); check_eq("sel_wrap", 32'(sel_ch), 0);
`ifndef SAVE_ON_STOP_EN
    cyc(1, 0, 0, 0, 0); check_eq("play_on", 32'(play_state), 1);
    cyc(1, 0, 0, 0, 0); check_eq("play_off", 32'(play_state), 0);
    cyc(1, 0, 0, 0, 0);
    cyc(0, 1, 0, 0, 0);
    check_eq("clr_while_play", 32'(clr_pulse), 0);
    check_eq("no_save_while_play", 32'(save_req), 0);
    cyc(1, 0, 0, 0, 0);
    cyc(0, 1, 0, 0, 0);
    check_eq("clr_pulse", 32'(clr_pulse), 1);
    check_eq("save_req_up", 32'(save_req), 1);
    check_eq("save_ch0", 32'(save_ch), 0);
    cyc(0, 0, 0, 0, 0); check_eq("clr_one_cycle", 32'(clr_pulse), 0);
    idle(3);
    cyc(0, 0, 0, 0, 1);
    check_eq("save_ack_drop", 32'(save_req), 0);
    check_eq("save_ack_err", 32'(err), 0);
    cyc(0, 1, 0, 0, 0);
    idle(7); check_eq("save_wait", 32'(save_req), 1);
    idle(1);
    check_eq("save_timeout", 32'(save_req), 0);
    check_eq("err_set", 32'(err), 1);
    cyc(1, 1, 1, 0, 0);
    check_eq("prio_play", 32'(play_state), 1);
    check_eq("prio_sel", 32'(sel_ch), 0);
    check_eq("prio_save", 32'(save_req), 0);
    cyc(1, 0, 0, 0, 0);
    cyc(0, 1, 0, 0, 0);
    cyc(0, 0, 1, 0, 0); check_eq("sel_in_save", 32'(sel_ch), 0);
    cyc(1, 0, 0, 0, 0); check_eq("start_in_save", 32'(play_state), 0);
    cyc(0, 0, 0, 0, 1);
    check_eq("err_sticky", 32'(err), 1);
`else
    cyc(0, 0, 1, 0, 0);
    cyc(1, 0, 0, 0, 0); check_eq("sos_play", 32'(play_state), 2);
    cyc(1, 0, 0, 0, 0);
    check_eq("sos_stop", 32'(play_state), 0);
    check_eq("sos_save_req", 32'(save_req), 1);
    check_eq("sos_save_ch", 32'(save_ch), 1);
    check_eq("sos_no_clr", 32'(clr_pulse), 0);
    cyc(0, 0, 0, 0, 1);
`endif
    cyc(0, 1, 0, 0, 0);
    mid_reset();

    for (int i = 0; i < 3000; i++) begin
      cyc($urandom_range(0, 3) == 0, $urandom_range(0, 3) == 0, $urandom_range(0, 3) == 0,
          $urandom_range(0, 9) == 0, $urandom_range(0, 9) == 0);
      if ((m_lreq || m_sreq) && $urandom_range(0, 199) == 0) mid_reset();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/key_ctrl_multi.md
Name: key_ctrl_multi

Overview:
Parametrised successor to the single-channel start/stop/clear key controller. Manages N_CH independent play/stop channels from three debounced key pulses: start/stop, clear and channel-select. Clear is valid only while the selected channel is stopped. A clear triggers an EEPROM save request through a req/ack handshake, and the block requests an EEPROM load once after reset. Sits between the key debounce modules and the counter/display and EEPROM (I2C) controllers.

Parameters:
N_CH, 2, number of channels (2..8)
CH_W, 1, select width; must satisfy 2**CH_W >= N_CH
ACK_TIMEOUT, 1000, sclk cycles to wait for load_ack/save_ack before aborting

Ports:
sclk  input  1  system clock
rst  input  1  asynchronous, active-high reset
key_start  input  1  one-cycle pulse; toggles play/stop of the selected channel
key_clr  input  1  one-cycle pulse; clears the selected channel if stopped
key_sel  input  1  one-cycle pulse; advances the selected channel
load_ack  input  1  EEPROM controller: load complete
save_ack  input  1  EEPROM controller: save complete
play_state  output  N_CH  per channel; 1 = play, 0 = stop
sel_ch  output  CH_W  currently selected channel
clr_pulse  output  N_CH  one-cycle clear strobe per channel
load_req  output  1  level; held until load_ack or timeout
save_req  output  1  level; held until save_ack or timeout
save_ch  output  CH_W  channel being saved; stable while save_req=1
busy  output  1  1 in S_LOAD or S_SAVE
err  output  1  sticky; set on any handshake timeout

Behaviour:
- Reset values: play_state=0, sel_ch=0, clr_pulse=0, load_req=0, save_req=0, save_ch=0, busy=0, err=0. The FSM enters S_LOAD.
- FSM states: S_LOAD, S_IDLE, S_SAVE. Timeout counter is cleared on every state entry.
- S_LOAD:
  - load_req=1 and busy=1 from the first cycle after reset release.
  - On load_ack: next cycle load_req=0, go to S_IDLE.
  - On ACK_TIMEOUT cycles without ack: err=1, load_req=0, go to S_IDLE.
  - All keys are ignored.
- S_IDLE: at most one key is acted on per cycle. Priority is key_start > key_clr > key_sel.
  - key_start: play_state[sel_ch] inverts on the next edge.
  - key_clr with play_state[sel_ch]=0:
    - clr_pulse[sel_ch]=1 for exactly one cycle, registered, on the next edge.
    - Same edge: save_ch<=sel_ch, save_req<=1, go to S_SAVE.
  - key_clr with play_state[sel_ch]=1: ignored. No pulse, no save.
  - key_sel: sel_ch<=sel_ch+1, wrapping from N_CH-1 to 0 (not 2**CH_W-1).
- S_SAVE:
  - busy=1; save_req held; save_ch frozen.
  - key_start, key_clr and key_sel are all dropped, not queued.
  - On save_ack: save_req=0 next cycle, go to S_IDLE.
  - On timeout: err=1, save_req=0, go to S_IDLE.
  - Channels already in play keep their state throughout.
- An ack arriving outside its matching request state is ignored.
- An ack in the same cycle the timeout expires counts as success; err is not set.
- err clears only on rst.
- rst asserted mid-handshake: all request lines drop immediately (asynchronously), then the load sequence restarts.

Optional Feature:
SAVE_ON_STOP_EN
- Defined: a key_start that changes the selected channel from play to stop also enters S_SAVE with save_ch=sel_ch. No clr_pulse is issued.
- Undefined: only key_clr triggers a save; stopping has no EEPROM side effect.

Test Plan:
- Release rst, hold load_ack=0 -> load_req=1, busy=1. Pulse load_ack at cycle 5 -> load_req=0 next cycle, err=0, keys now accepted.
- N_CH=3, load_ack tied high: key_sel x3 -> sel_ch goes 1,2,0. key_start -> play_state=3'b001. Second key_start -> 3'b000.
- Channel 0 playing: key_clr -> no clr_pulse, save_req stays 0. Stop it, then key_clr -> clr_pulse=3'b001 for 1 cycle, save_req=1, save_ch=0. save_ack after 10 cycles -> save_req=0.
- ACK_TIMEOUT=8, save_ack never asserted -> save_req drops after 8 cycles, err=1 and stays 1 until rst.
- key_start, key_clr and key_sel pulsed in the same cycle in S_IDLE -> only play_state toggles. key_sel during S_SAVE -> sel_ch unchanged.
- With SAVE_ON_STOP_EN: channel 1 play -> key_start -> play_state[1]=0, save_req=1, save_ch=1, clr_pulse stays 0.
